// File: rtl/delta_seq.sv
// delta_seq: serial backpropagation delta engine (output cost/delta and hidden
// delta) that time-shares one Q8.24 multiplier across a one-step-per-cycle FSM.
module delta_seq #(
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [N_HL_P*WIDTH-1:0]       i_hd_a,
  input  logic [N_HL_P*N_OUT*WIDTH-1:0] i_out_w,
  input  logic [N_OUT*WIDTH-1:0]        i_out_a,
  input  logic [N_OUT*WIDTH-1:0]        i_t,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [N_OUT*WIDTH-1:0]        o_cost,
  output logic [N_OUT*WIDTH-1:0]        o_dlto,
  output logic [N_HL_P*WIDTH-1:0]       o_dlth
);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] LAST_HL  = CNT_W'(N_HL_P - 1);
  localparam logic [CNT_W-1:0] SUB_SD   = CNT_W'(N_OUT);
  localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(N_OUT + 1);
  localparam logic [WIDTH-1:0] Q_ONE    = 32'h0100_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_HID  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_idx, r_sub, w_idx_nxt, w_sub_nxt;
  logic [WIDTH-1:0]              r_acc, r_tmp;
  logic [N_HL_P*WIDTH-1:0]       r_hd_a;
  logic [N_HL_P*N_OUT*WIDTH-1:0] r_out_w;
  logic [N_OUT*WIDTH-1:0]        r_out_a;
  logic [WIDTH-1:0]              w_a_k, w_cost_k, w_dlto_s, w_w_js, w_hd_j;
  logic [WIDTH-1:0]              w_mul_x, w_mul_y, w_mul;

  // Q8.24 multiply: full signed product, arithmetic shift keeps bits [55:24] (floor).
  function automatic logic [WIDTH-1:0] mul_q(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] p;
    p = $signed(x) * $signed(y);
    mul_q = WIDTH'(p >>> 7'd24);
  endfunction

  assign o_busy  = (r_state != S_IDLE);
  assign o_valid = (r_state == S_DONE);

  // Operand fetch from the captured copies, indexed by the step counters.
  always_comb begin
    w_a_k    = '0;
    w_cost_k = '0;
    w_dlto_s = '0;
    w_w_js   = '0;
    w_hd_j   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_a_k    = (i == int'(r_idx)) ? r_out_a[i*WIDTH +: WIDTH] : w_a_k;
      w_cost_k = (i == int'(r_idx)) ? o_cost[i*WIDTH +: WIDTH]  : w_cost_k;
      w_dlto_s = (i == int'(r_sub)) ? o_dlto[i*WIDTH +: WIDTH]  : w_dlto_s;
    end
    for (int j = 0; j < N_HL_P; j++) begin
      w_hd_j = (j == int'(r_idx)) ? r_hd_a[j*WIDTH +: WIDTH] : w_hd_j;
      for (int k = 0; k < N_OUT; k++) begin
        w_w_js = ((j == int'(r_idx)) && (k == int'(r_sub))) ?
                 r_out_w[(j*N_OUT+k)*WIDTH +: WIDTH] : w_w_js;
      end
    end
  end

  // Shared multiplier operand select for the current sub-step.
  always_comb begin
    w_mul_x = '0;
    w_mul_y = '0;
    case (r_state)
      S_OUT: begin
        if (r_sub == '0) begin
          w_mul_x = w_a_k;
          w_mul_y = Q_ONE - w_a_k;
        end else begin
          w_mul_x = w_cost_k;
          w_mul_y = r_tmp;
        end
      end
      S_HID: begin
        if (r_sub < SUB_SD) begin
          w_mul_x = w_dlto_s;
          w_mul_y = w_w_js;
        end else if (r_sub == SUB_SD) begin
          w_mul_x = w_hd_j;
          w_mul_y = Q_ONE - w_hd_j;
        end else begin
          w_mul_x = r_acc;
          w_mul_y = r_tmp;
        end
      end
      default: begin
        w_mul_x = '0;
        w_mul_y = '0;
      end
    endcase
    w_mul = mul_q(w_mul_x, w_mul_y);
  end

  // Next-state and step-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sub_nxt   = r_sub;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_OUT;
          w_idx_nxt   = '0;
          w_sub_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        if (r_sub == '0) begin
          w_sub_nxt = 8'd1;
        end else if (r_idx == LAST_OUT) begin
          w_sub_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_HID;
        end else begin
          w_sub_nxt = '0;
          w_idx_nxt = r_idx + 8'd1;
        end
      end
      S_HID: begin
        if (r_sub != SUB_LAST) begin
          w_sub_nxt = r_sub + 8'd1;
        end else if (r_idx == LAST_HL) begin
          w_sub_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_sub_nxt = '0;
          w_idx_nxt = r_idx + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_sub_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sub   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  // Datapath: input capture, then one multiplier result written per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_tmp   <= '0;
      r_hd_a  <= '0;
      r_out_w <= '0;
      r_out_a <= '0;
      o_cost  <= '0;
      o_dlto  <= '0;
      o_dlth  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_hd_a  <= i_hd_a;
            r_out_w <= i_out_w;
            r_out_a <= i_out_a;
            r_acc   <= '0;
            for (int i = 0; i < N_OUT; i++) begin
              o_cost[i*WIDTH +: WIDTH] <= i_out_a[i*WIDTH +: WIDTH] - i_t[i*WIDTH +: WIDTH];
            end
          end
        end
        S_OUT: begin
          if (r_sub == '0) begin
            r_tmp <= w_mul;
          end else begin
            for (int i = 0; i < N_OUT; i++) begin
              if (i == int'(r_idx)) o_dlto[i*WIDTH +: WIDTH] <= w_mul;
            end
          end
        end
        S_HID: begin
          // The first product of each hidden neuron restarts the accumulator.
          if (r_sub < SUB_SD) begin
            r_acc <= (r_sub == '0) ? w_mul : (r_acc + w_mul);
          end else if (r_sub == SUB_SD) begin
            r_tmp <= w_mul;
          end else begin
            for (int j = 0; j < N_HL_P; j++) begin
              if (j == int'(r_idx)) o_dlth[j*WIDTH +: WIDTH] <= w_mul;
            end
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delta_seq.sv
// Scoreboard bench for delta_seq: directed vectors with hand-computed results,
// expectations queued at issue time and checked by a monitor on each o_valid.
module tb_delta_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [95:0]  i_hd_a;
  logic [191:0] i_out_w;
  logic [63:0]  i_out_a;
  logic [63:0]  i_t;
  logic         o_busy;
  logic         o_valid;
  logic [63:0]  o_cost;
  logic [63:0]  o_dlto;
  logic [95:0]  o_dlth;

  delta_seq #(.N_HL_P(3), .N_OUT(2), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_hd_a(i_hd_a), .i_out_w(i_out_w), .i_out_a(i_out_a), .i_t(i_t),
    .o_busy(o_busy), .o_valid(o_valid),
    .o_cost(o_cost), .o_dlto(o_dlto), .o_dlth(o_dlth)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] cost;
    logic [63:0] dlto;
    logic [95:0] dlth;
    logic [31:0] vcyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_issued = 0;

  // Hand-computed vectors (slice 0 is the rightmost element of each concatenation).
  localparam logic [63:0]  BAS_A  = {32'h0080_0000, 32'h0080_0000};
  localparam logic [63:0]  BAS_T  = {32'h0000_0000, 32'h0100_0000};
  localparam logic [95:0]  BAS_HD = {32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
  localparam logic [191:0] BAS_W  = {32'h0080_0000, 32'h0100_0000, 32'h0080_0000,
                                     32'h0100_0000, 32'h0080_0000, 32'h0100_0000};
  localparam exp_t BAS_E = {64'h0080_0000_FF80_0000, 64'h0020_0000_FFE0_0000,
                            96'hFFFC_0000_FFFC_0000_FFFC_0000, 32'd0};

  localparam logic [63:0] TRN_A = {32'h0080_0000, 32'h0080_0000};
  localparam logic [63:0] TRN_T = {32'h0000_0000, 32'h0080_0001};
  localparam exp_t TRN_E = {64'h0080_0000_FFFF_FFFF, 64'h0020_0000_FFFF_FFFF,
                            96'h0003_FFFF_0003_FFFF_0003_FFFF, 32'd0};

  localparam logic [63:0] SAT_A  = {32'h0080_0000, 32'h0100_0000};
  localparam logic [63:0] SAT_T  = {32'h0100_0000, 32'h0000_0000};
  localparam logic [95:0] SAT_HD = {32'h0100_0000, 32'h0080_0000, 32'h0000_0000};
  localparam exp_t SAT_E = {64'hFF80_0000_0100_0000, 64'hFFE0_0000_0000_0000,
                            96'h0000_0000_FFFC_0000_0000_0000, 32'd0};

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every o_valid cycle pops one expectation and checks it.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      n_valid++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: o_valid at cycle %0d with empty scoreboard", cyc);
      end else begin
        e = q.pop_front();
        cmp("valid_cycle", 128'(cyc), 128'(e.vcyc));
        cmp("cost", 128'(o_cost), 128'(e.cost));
        cmp("dlto", 128'(o_dlto), 128'(e.dlto));
        cmp("dlth", 128'(o_dlth), 128'(e.dlth));
      end
    end
  end

  // Called just after a negedge: drives a start sampled on the next edge (E0).
  task automatic issue(input logic [63:0] a, input logic [63:0] t, input logic [95:0] hd,
                       input logic [191:0] w, input bit push, input exp_t e);
    i_out_a = a;
    i_t     = t;
    i_hd_a  = hd;
    i_out_w = w;
    i_start = 1'b1;
    if (push) begin
      e.vcyc = 32'(cyc + 17);
      q.push_back(e);
      n_issued++;
    end
    @(negedge clk);
    i_start = 1'b0;
    cmp("busy_after_accept", 128'(o_busy), 128'(1));
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no o_valid within 40 cycles", tag);
    end
    @(negedge clk);
    cmp({tag, "_busy_end"}, 128'(o_busy), 128'(0));
    cmp({tag, "_valid_end"}, 128'(o_valid), 128'(0));
  endtask

  task automatic check_cleared(input string tag);
    cmp({tag, "_busy"}, 128'(o_busy), 128'(0));
    cmp({tag, "_valid"}, 128'(o_valid), 128'(0));
    cmp({tag, "_cost"}, 128'(o_cost), 128'(0));
    cmp({tag, "_dlto"}, 128'(o_dlto), 128'(0));
    cmp({tag, "_dlth"}, 128'(o_dlth), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_hd_a = '0;
    i_out_w = '0;
    i_out_a = '0;
    i_t = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    @(negedge clk);
    issue(BAS_A, BAS_T, BAS_HD, BAS_W, 1'b1, BAS_E);
    wait_done("basic");
    issue(TRN_A, TRN_T, BAS_HD, BAS_W, 1'b1, TRN_E);
    wait_done("trunc");
    issue(SAT_A, SAT_T, SAT_HD, BAS_W, 1'b1, SAT_E);
    wait_done("sat");

    // Starts while busy (E0+5 and DONE) must be ignored; E(C+2) start is accepted.
    issue(BAS_A, BAS_T, BAS_HD, BAS_W, 1'b1, BAS_E);
    repeat (4) @(negedge clk);
    i_out_a = TRN_A;
    i_t     = TRN_T;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) break;
    end
    i_start = 1'b1;
    @(negedge clk);
    cmp("busy_ignored_idle", 128'(o_busy), 128'(0));
    issue(SAT_A, SAT_T, SAT_HD, BAS_W, 1'b1, SAT_E);
    wait_done("after_busy");

    // Reset at E0+7 aborts the run; a fresh run reproduces the basic results.
    issue(BAS_A, BAS_T, BAS_HD, BAS_W, 1'b0, BAS_E);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midrun_reset");
    rst = 1'b0;
    issue(BAS_A, BAS_T, BAS_HD, BAS_W, 1'b1, BAS_E);
    wait_done("post_reset");

    repeat (3) @(negedge clk);
    cmp("valid_pulses", 128'(n_valid), 128'(n_issued));
    cmp("scoreboard_empty", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
